// File: rtl/y86_regfile_sb.sv
// Y86 register file: two bypassed read ports, two write ports (M over E),
// and a per-register pending-write scoreboard that raises decode stalls.
module y86_regfile_sb #(
    parameter int DATA_W  = 64,
    parameter int NREGS   = 15,
    parameter int ADDR_W  = 4,
    parameter int SP_IDX  = 4,
    parameter int SP_INIT = 1023,
    parameter int PEND_W  = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [ADDR_W-1:0]       srcA,
    input  logic [ADDR_W-1:0]       srcB,
    output logic [DATA_W-1:0]       valA,
    output logic [DATA_W-1:0]       valB,
    input  logic                    issue_valid,
    input  logic [ADDR_W-1:0]       issue_dstE,
    input  logic [ADDR_W-1:0]       issue_dstM,
    output logic                    stall,
    input  logic [ADDR_W-1:0]       wb_dstE,
    input  logic [DATA_W-1:0]       wb_valE,
    input  logic [ADDR_W-1:0]       wb_dstM,
    input  logic [DATA_W-1:0]       wb_valM,
    output logic [NREGS*DATA_W-1:0] regs_flat
);

    localparam logic [ADDR_W:0]   NREGS_L = (ADDR_W+1)'(NREGS);
    localparam logic [PEND_W-1:0] CMAX    = '1;

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] regs_d [NREGS];
    logic [PEND_W-1:0] cnt_q  [NREGS];
    logic [PEND_W-1:0] cnt_d  [NREGS];
    logic              accept;

    function automatic logic idx_ok(input logic [ADDR_W-1:0] a);
        return {1'b0, a} < NREGS_L;
    endfunction

    function automatic logic wb_hit(input logic [ADDR_W-1:0] a);
        return idx_ok(a) && ((a == wb_dstE) || (a == wb_dstM));
    endfunction

    function automatic logic [PEND_W-1:0] cnt_of(input logic [ADDR_W-1:0] a);
        logic [PEND_W-1:0] c;
        c = '0;
        for (int r = 0; r < NREGS; r++) begin
            if (a == ADDR_W'(r)) c = cnt_q[r];
        end
        return c;
    endfunction

    // Outstanding writes left after this cycle's writeback is retired.
    function automatic logic pend_pos(input logic [ADDR_W-1:0] a);
        logic [PEND_W-1:0] c;
        c = cnt_of(a);
        if (wb_hit(a) && (c != '0)) c = c - 1'b1;
        return idx_ok(a) && (c != '0);
    endfunction

    function automatic logic full(input logic [ADDR_W-1:0] a);
        return idx_ok(a) && (cnt_of(a) == CMAX) && !wb_hit(a);
    endfunction

    // Writeback data bypasses the array so decode sees it in the same cycle.
    function automatic logic [DATA_W-1:0] rd(input logic [ADDR_W-1:0] a);
        logic [DATA_W-1:0] v;
        v = '0;
        if (idx_ok(a)) begin
            if (a == wb_dstM) begin
                v = wb_valM;
            end else if (a == wb_dstE) begin
                v = wb_valE;
            end else begin
                for (int r = 0; r < NREGS; r++) begin
                    if (a == ADDR_W'(r)) v = regs_q[r];
                end
            end
        end
        return v;
    endfunction

    // Read ports, stall decision and issue acceptance.
    always_comb begin
        valA   = rd(srcA);
        valB   = rd(srcB);
        stall  = issue_valid &&
                 (pend_pos(srcA) || pend_pos(srcB) ||
                  full(issue_dstE) || full(issue_dstM));
        accept = issue_valid && !stall;
    end

    // Next-state for register data and scoreboard counters.
    always_comb begin
        for (int r = 0; r < NREGS; r++) begin
            logic inc;
            logic dec;
            regs_d[r] = regs_q[r];
            cnt_d[r]  = cnt_q[r];
            if (wb_dstE == ADDR_W'(r)) regs_d[r] = wb_valE;
            if (wb_dstM == ADDR_W'(r)) regs_d[r] = wb_valM;
            inc = accept && ((issue_dstE == ADDR_W'(r)) ||
                             (issue_dstM == ADDR_W'(r)));
            dec = ((wb_dstE == ADDR_W'(r)) || (wb_dstM == ADDR_W'(r))) &&
                  (cnt_q[r] != '0);
            if (inc && !dec) cnt_d[r] = cnt_q[r] + 1'b1;
            else if (dec && !inc) cnt_d[r] = cnt_q[r] - 1'b1;
        end
    end

    // State registers; reset reloads the stack pointer and clears pending counts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREGS; r++) begin
                regs_q[r] <= (r == SP_IDX) ? DATA_W'(SP_INIT) : '0;
                cnt_q[r]  <= '0;
            end
        end else begin
            for (int r = 0; r < NREGS; r++) begin
                regs_q[r] <= regs_d[r];
                cnt_q[r]  <= cnt_d[r];
            end
        end
    end

    // Flattened view of the architectural registers.
    always_comb begin
        regs_flat = '0;
        for (int r = 0; r < NREGS; r++) begin
            regs_flat[r*DATA_W +: DATA_W] = regs_q[r];
        end
    end

endmodule

// File: doc/y86_regfile_sb.md
Name: y86_regfile_sb

Overview:
Parametrised Y86 register file for the pipelined processor. Provides two combinational read ports (srcA/srcB) with write-through bypass and two clocked write ports (E and M, with M taking priority). A per-register pending-write scoreboard tracks in-flight destinations and raises a stall whenever decode reads a register whose value is not yet available.

Parameters:
DATA_W, 64, register width in bits
NREGS, 15, number of architectural registers (index 0..NREGS-1)
ADDR_W, 4, register index width; any index >= NREGS (including 4'hF = RNONE) means "no register"
SP_IDX, 4, index of the stack pointer
SP_INIT, 1023, reset value of the stack pointer
PEND_W, 2, width of each scoreboard counter (max in-flight writes per register = 2^PEND_W-1)

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
srcA  input  ADDR_W  read port A index
srcB  input  ADDR_W  read port B index
valA  output  DATA_W  read data A (combinational)
valB  output  DATA_W  read data B (combinational)
issue_valid  input  1  decode requests issue of an instruction
issue_dstE  input  ADDR_W  E destination of issuing instruction
issue_dstM  input  ADDR_W  M destination of issuing instruction
stall  output  1  issue blocked this cycle (combinational)
wb_dstE  input  ADDR_W  writeback E destination
wb_valE  input  DATA_W  writeback E data
wb_dstM  input  ADDR_W  writeback M destination
wb_valM  input  DATA_W  writeback M data
regs_flat  output  NREGS*DATA_W  all registers, reg i at bits [i*DATA_W +: DATA_W], registered

Behaviour:
- Reset (async, rst_n=0): all registers are 0 except reg[SP_IDX]=SP_INIT, and all scoreboard counters are 0. regs_flat updates immediately. stall is 0 when no register is pending.
- Write: on posedge clk, reg[wb_dstE]<=wb_valE if valid, and reg[wb_dstM]<=wb_valM if valid. If wb_dstE==wb_dstM (valid), the M write wins. Invalid indices are ignored.
- Read: read index invalid -> 0. Otherwise the result is selected in this priority order: wb_dstM match -> wb_valM; wb_dstE match -> wb_valE; else reg. valA and valB are independent.
- pend(r): counter[r] minus 1 if r is written back this cycle (E or M; counted once if both match). Floored at 0.
- stall = issue_valid AND any of the following:
  - srcA valid and pend(srcA)>0
  - srcB valid and pend(srcB)>0
  - a valid issue destination has counter[dst]==max and is not written back this cycle
- Issue accepted = issue_valid AND !stall.
- Counter update per register r, each posedge:
  - +1 if an accepted issue targets r (dstE and/or dstM; counted once if both equal r).
  - -1 if writeback targets r (counted once if both ports match) and counter>0.
  - Simultaneous +1 and -1 leaves the counter unchanged.
  - Writeback to a register with counter 0 still writes data; the counter stays 0 (no underflow).
- Stalled issue leaves counters untouched. Upstream must hold srcA/srcB/dst stable while stall=1.
- Reset mid-operation: all counters clear and registers reinitialise regardless of in-flight writes. Writebacks arriving after reset update data only.
- No latency on reads. Written data is visible in regs_flat one cycle after the write edge, and visible on valA/valB in the same cycle via bypass.

Test Plan:
1. Reset, then srcA=4, srcB=0 -> valA=1023, valB=0, stall=0; regs_flat slot4=1023, all other slots 0.
2. wb_dstE=2, wb_valE=0x55, srcA=2 in same cycle -> valA=0x55 (bypass); after edge, with wb_dstE=F, valA=0x55 from array.
3. wb_dstE=4, wb_valE=1015, wb_dstM=4, wb_valM=0x99 -> after edge reg4=0x99; during that cycle srcA=4 reads 0x99.
4. Issue dstE=3 accepted. Next cycle issue_valid, srcA=3 -> stall=1, counter unchanged. Then wb_dstE=3, wb_valE=7 in the same cycle as the read -> stall=0, valA=7.
5. With PEND_W=2, issue dstE=1 three times with no writeback -> the fourth issue targeting rB=1 asserts stall. Same cycle with wb_dstE=1 -> stall=0, counter stays 3.
6. Pend reg5 (counter=1), assert rst_n=0 for 1 cycle, then read srcA=5 with issue_valid -> stall=0, valA=0.
